// File: rtl/gbsha_ttfir_host.sv
// Host-side driver for the 8-pin FIR tile: sequences tile reset, mode and coefficient
// ticks, then streams samples in and reassembles the tile's byte-serial sums.
module gbsha_ttfir_host #(
   parameter int N_TAPS      = 4,
   parameter int BW_in       = 6,
   parameter int BW_out      = 8,
   parameter int BW_sum      = 13,
   parameter int HALF_PERIOD = 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic                      cfg_lsb_mode,
   input  logic [N_TAPS*BW_in-1:0]   cfg_coef,
   input  logic [BW_in-1:0]          s_sample,
   input  logic                      s_valid,
   output logic                      s_ready,
   output logic [BW_sum-1:0]         m_result,
   output logic                      m_valid,
   input  logic                      m_ready,
   output logic                      busy,
   output logic [7:0]                fir_io_in,
   input  logic [7:0]                fir_io_out
);

   localparam int CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
   localparam int IW = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
   localparam int LW = BW_sum - BW_out;
   localparam logic [CW-1:0] HP_LAST  = CW'(HALF_PERIOD - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(N_TAPS - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_TRST  = 3'd1,
      S_TMODE = 3'd2,
      S_TCOEF = 3'd3,
      S_RUN   = 3'd4,
      S_TMSB  = 3'd5,
      S_TLSB  = 3'd6,
      S_HOLD  = 3'd7
   } state_t;

   state_t                    state_q;
   logic                      tick_q;
   logic                      clk_q;
   logic                      trst_q;
   logic [BW_in-1:0]          data_q;
   logic [CW-1:0]             cnt_q;
   logic [IW-1:0]             cidx_q;
   logic                      lsb_mode_q;
   logic [N_TAPS*BW_in-1:0]   coef_q;
   logic [BW_out-1:0]         msb_q;
   logic [BW_sum-1:0]         m_result_q;
   logic                      m_valid_q;
   logic                      busy_q;

   logic                      phase_last;
   logic                      tick_end;
   logic                      final_st;
   logic                      slot_free;
   logic                      start_ok;
   logic                      accept;
   logic [IW-1:0]             cidx_dn;
   logic [BW_sum-1:0]         final_res;

   assign phase_last = (cnt_q == HP_LAST);
   assign tick_end   = tick_q && clk_q && phase_last;
   assign final_st   = (state_q == S_TLSB) || ((state_q == S_TMSB) && !lsb_mode_q);
   assign slot_free  = !m_valid_q || m_ready;
   assign start_ok   = start && ((state_q == S_IDLE) || ((state_q == S_RUN) && !m_valid_q));
   // The edge that closes the last tick of a sample is also the next LOW entry, so
   // samples can be taken back-to-back there as well as from the idle point.
   assign s_ready    = (((state_q == S_RUN) && !start_ok) || (final_st && tick_end)) && slot_free;
   assign accept     = s_valid && s_ready;
   assign cidx_dn    = cidx_q - IW'(1);
   // The tile is stalled while no tick runs, so its pins still hold the byte in HOLD.
   assign final_res  = lsb_mode_q ? {msb_q, fir_io_out[LW-1:0]} : {fir_io_out, {LW{1'b0}}};

   assign fir_io_in  = {data_q, trst_q, clk_q};
   assign m_result   = m_result_q;
   assign m_valid    = m_valid_q;
   assign busy       = busy_q;

   // Tick engine, configuration sequencer and result handshake.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         tick_q     <= 1'b0;
         clk_q      <= 1'b0;
         trst_q     <= 1'b1;
         data_q     <= '0;
         cnt_q      <= '0;
         cidx_q     <= '0;
         lsb_mode_q <= 1'b0;
         coef_q     <= '0;
         msb_q      <= '0;
         m_result_q <= '0;
         m_valid_q  <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         if (m_valid_q && m_ready) begin
            m_valid_q <= 1'b0;
         end
         if (tick_q) begin
            if (!phase_last) begin
               cnt_q <= cnt_q + CW'(1);
            end else if (!clk_q) begin
               clk_q <= 1'b1;
               cnt_q <= '0;
            end else begin
               clk_q  <= 1'b0;
               tick_q <= 1'b0;
               cnt_q  <= '0;
            end
         end

         case (state_q)
            S_IDLE, S_RUN: begin
               if (start_ok) begin
                  state_q    <= S_TRST;
                  busy_q     <= 1'b1;
                  lsb_mode_q <= cfg_lsb_mode;
                  coef_q     <= cfg_coef;
                  trst_q     <= 1'b1;
                  data_q     <= '0;
                  tick_q     <= 1'b1;
               end else if (accept) begin
                  state_q <= S_TMSB;
                  data_q  <= s_sample;
                  tick_q  <= 1'b1;
               end
            end
            S_TRST: begin
               if (tick_end) begin
                  state_q <= S_TMODE;
                  trst_q  <= 1'b0;
                  data_q  <= {{(BW_in-1){1'b0}}, lsb_mode_q};
                  tick_q  <= 1'b1;
               end
            end
            S_TMODE: begin
               if (tick_end) begin
                  state_q <= S_TCOEF;
                  cidx_q  <= IDX_LAST;
                  data_q  <= coef_q[IDX_LAST*BW_in +: BW_in];
                  tick_q  <= 1'b1;
               end
            end
            S_TCOEF: begin
               if (tick_end) begin
                  if (cidx_q == '0) begin
                     state_q <= S_RUN;
                     busy_q  <= 1'b0;
                  end else begin
                     cidx_q <= cidx_dn;
                     data_q <= coef_q[cidx_dn*BW_in +: BW_in];
                     tick_q <= 1'b1;
                  end
               end
            end
            S_TMSB, S_TLSB: begin
               if (tick_end) begin
                  if ((state_q == S_TMSB) && lsb_mode_q) begin
                     msb_q   <= fir_io_out;
                     state_q <= S_TLSB;
                     data_q  <= '0;
                     tick_q  <= 1'b1;
                  end else begin
                     if (state_q == S_TMSB) begin
                        msb_q <= fir_io_out;
                     end
                     if (slot_free) begin
                        m_result_q <= final_res;
                        m_valid_q  <= 1'b1;
                        if (accept) begin
                           state_q <= S_TMSB;
                           data_q  <= s_sample;
                           tick_q  <= 1'b1;
                        end else begin
                           state_q <= S_RUN;
                        end
                     end else begin
                        state_q <= S_HOLD;
                     end
                  end
               end
            end
            S_HOLD: begin
               if (m_ready) begin
                  m_result_q <= final_res;
                  m_valid_q  <= 1'b1;
                  state_q    <= S_RUN;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gbsha_ttfir_host.sv
// Directed bench for gbsha_ttfir_host with a behavioural model of the 8-pin FIR tile.
module tb_gbsha_ttfir_host;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        cfg_lsb_mode;
   logic [23:0] cfg_coef;
   logic [5:0]  s_sample;
   logic        s_valid;
   logic        s_ready;
   logic [12:0] m_result;
   logic        m_valid;
   logic        m_ready;
   logic        busy;
   logic [7:0]  fir_io_in;
   logic [7:0]  tile_out = 8'h00;

   int n_checks = 0;
   int n_errors = 0;

   logic [12:0] got[$];
   logic [7:0]  edge_log[$];

   localparam logic [23:0] C1234 = {6'd1, 6'd2, 6'd3, 6'd4};
   localparam logic [23:0] CNEG  = {6'h20, 6'h20, 6'h20, 6'h20};

   gbsha_ttfir_host dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .cfg_lsb_mode (cfg_lsb_mode),
      .cfg_coef     (cfg_coef),
      .s_sample     (s_sample),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .m_result     (m_result),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .busy         (busy),
      .fir_io_in    (fir_io_in),
      .fir_io_out   (tile_out)
   );

   always #5 clk = ~clk;

   // Tile model: reset tick, mode tick, coefficient ticks (highest first), then samples.
   logic signed [5:0] tcoef[4];
   logic signed [5:0] tx[4];
   int               tphase = 0;
   int               tk = 0;
   int               acc;
   logic             tmode = 1'b0;
   logic             tpend = 1'b0;
   logic [31:0]      tsum = 32'd0;

   always @(posedge fir_io_in[0]) begin
      edge_log.push_back(fir_io_in);
      if (fir_io_in[1]) begin
         tphase = 0;
         tpend  = 1'b0;
         for (int i = 0; i < 4; i++) tx[i] = 6'sd0;
      end else if (tphase == 0) begin
         tmode  = fir_io_in[2];
         tphase = 1;
         tk     = 0;
      end else if (tphase == 1) begin
         tcoef[3-tk] = fir_io_in[7:2];
         tk++;
         if (tk == 4) tphase = 2;
      end else if (tmode && tpend) begin
         tile_out = {3'b000, tsum[4:0]};
         tpend    = 1'b0;
      end else begin
         for (int i = 3; i > 0; i--) tx[i] = tx[i-1];
         tx[0] = fir_io_in[7:2];
         acc = 0;
         for (int i = 0; i < 4; i++) acc += tcoef[i] * tx[i];
         tsum     = acc;
         tile_out = tsum[12:5];
         tpend    = tmode;
      end
   end

   always @(negedge clk) begin
      if (m_valid && m_ready) got.push_back(m_result);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic configure(input logic [23:0] coef, input logic lsb);
      int n;
      @(posedge clk); #1;
      cfg_coef     = coef;
      cfg_lsb_mode = lsb;
      start        = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("cfg_busy_rise", busy, 1);
      n = 0;
      while (busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("cfg_busy_fall", busy, 0);
   endtask

   task automatic send(input logic [5:0] x);
      int n;
      @(posedge clk); #1;
      s_valid  = 1'b1;
      s_sample = x;
      n = 0;
      @(negedge clk);
      while (!s_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("send_ready", s_ready, 1);
      @(posedge clk); #1;
      s_valid = 1'b0;
   endtask

   task automatic expect4(input string tag, input logic [12:0] e0, input logic [12:0] e1,
                          input logic [12:0] e2, input logic [12:0] e3);
      logic [12:0] ev[4];
      int n;
      ev[0] = e0; ev[1] = e1; ev[2] = e2; ev[3] = e3;
      n = 0;
      while (got.size() < 4 && n < 300) begin
         @(negedge clk);
         n++;
      end
      repeat (10) @(negedge clk);
      chk({tag, "_count"}, got.size(), 4);
      for (int i = 0; i < 4; i++) begin
         if (i < got.size()) chk($sformatf("%s_r%0d", tag, i), got[i], ev[i]);
      end
      got.delete();
   endtask

   initial begin
      logic [7:0] exp_e[6];
      int e0;
      int n;
      exp_e[0] = 8'h03; exp_e[1] = 8'h01; exp_e[2] = 8'h05;
      exp_e[3] = 8'h09; exp_e[4] = 8'h0D; exp_e[5] = 8'h11;

      reset = 1'b1; start = 1'b0; cfg_lsb_mode = 1'b0; cfg_coef = 24'h000000;
      s_sample = 6'd0; s_valid = 1'b0; m_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_io", fir_io_in, 8'h02);
      chk("rst_s_ready", s_ready, 0);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_m_result", m_result, 0);
      repeat (20) @(negedge clk);
      chk("rst_no_edges", edge_log.size(), 0);

      // Configuration pin sequence
      e0 = edge_log.size();
      configure(C1234, 1'b0);
      chk("cfg_edges", edge_log.size() - e0, 6);
      for (int i = 0; i < 6; i++) begin
         if (e0 + i < edge_log.size()) chk($sformatf("cfg_edge%0d", i), edge_log[e0+i], exp_e[i]);
      end
      chk("cfg_s_ready", s_ready, 1);
      chk("cfg_bit0_idle", fir_io_in[0], 0);

      configure(C1234, 1'b1);
      send(6'd31); send(6'd0); send(6'd0); send(6'd0);
      expect4("lsb", 13'd124, 13'd93, 13'd62, 13'd31);

      configure(C1234, 1'b0);
      send(6'd31); send(6'd0); send(6'd0); send(6'd0);
      expect4("msb", 13'd96, 13'd64, 13'd32, 13'd0);

      configure(CNEG, 1'b1);
      send(6'h20); send(6'h20); send(6'h20); send(6'h20);
      expect4("wrap", 13'h0400, 13'h0800, 13'h0C00, 13'h1000);

      // Back-pressure on the result stream
      configure(C1234, 1'b1);
      m_ready = 1'b0;
      send(6'd31);
      n = 0;
      while (!m_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("bp_valid", m_valid, 1);
      @(posedge clk); #1;
      s_valid  = 1'b1;
      s_sample = 6'd0;
      e0 = edge_log.size();
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         chk("bp_bit0", fir_io_in[0], 0);
         chk("bp_s_ready", s_ready, 0);
         chk("bp_result", m_result, 13'd124);
      end
      chk("bp_no_edges", edge_log.size() - e0, 0);
      @(posedge clk); #1;
      m_ready = 1'b1;
      n = 0;
      @(negedge clk);
      while (!s_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("bp_release_ready", s_ready, 1);
      @(posedge clk); #1;
      s_valid = 1'b0;
      send(6'd0); send(6'd0);
      expect4("bp", 13'd124, 13'd93, 13'd62, 13'd31);

      // Reset while coefficient ticks are running
      e0 = edge_log.size();
      @(posedge clk); #1;
      cfg_coef = CNEG; cfg_lsb_mode = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n = 0;
      while (edge_log.size() < e0 + 3 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("mid_in_coef", busy, 1);
      reset = 1'b1;
      #1;
      chk("mid_rst_io", fir_io_in, 8'h02);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_s_ready", s_ready, 0);
      chk("mid_rst_m_valid", m_valid, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      e0 = edge_log.size();
      repeat (10) @(negedge clk);
      chk("mid_idle_edges", edge_log.size() - e0, 0);
      chk("mid_idle_ready", s_ready, 0);
      configure(C1234, 1'b1);
      send(6'd31); send(6'd0); send(6'd0); send(6'd0);
      expect4("restart", 13'd124, 13'd93, 13'd62, 13'd31);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/gbsha_ttfir_host.md
Name: gbsha_ttfir_host

Overview:
- Host-side driver for the 8-bit-pin FIR tile, i.e. the other end of its pin protocol.
- Drives all tile inputs as registered outputs: tile clock on bit 0, tile reset on bit 1, 6-bit data on bits 7:2.
- Runs the sequence reset → mode tick → 4 coefficient ticks, then streams samples from a valid/ready source.
- Reassembles each 13-bit filter sum from the tile's 8-bit output into a valid/ready result stream.

Parameters:
- N_TAPS, 4, taps in the tile; number of coefficient ticks.
- BW_in, 6, sample/coefficient width.
- BW_out, 8, tile output width.
- BW_sum, 13, tile accumulator width; width of m_result.
- HALF_PERIOD, 1, system cycles per tile-clock phase (low and high); must be ≥1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to (re)configure the tile.
- cfg_lsb_mode  in  1  1 = read 13-bit sums; 0 = MSB byte only.
- cfg_coef  in  N_TAPS*BW_in  coefficient k at bits [k*BW_in +: BW_in], signed.
- s_sample  in  BW_in  signed input sample.
- s_valid  in  1  sample valid.
- s_ready  out  1  sample accepted when s_valid && s_ready.
- m_result  out  BW_sum  signed filter sum.
- m_valid  out  1  result valid.
- m_ready  in  1  result consumed when m_valid && m_ready.
- busy  out  1  high while reset/config ticks are in progress.
- fir_io_in  out  8  to tile: [0] tile clock, [1] tile reset, [7:2] data.
- fir_io_out  in  8  from tile.

Behaviour:
- Reset (async): state IDLE; fir_io_in=8'h02 (tile clock low, tile reset high, data 0); s_ready=0, m_valid=0, m_result=0, busy=0; phase counter 0.
- Tile tick: LOW phase (bit0=0; reset and data bits updated on entry) for HALF_PERIOD cycles, then HIGH phase (bit0=1; data held) for HALF_PERIOD cycles.
  - fir_io_out is captured on the system edge that ends the HIGH phase.
  - Data and reset bits only change at LOW-phase entry.
  - No tick is ever started without a reason; with no tick pending, bit0 stays 0 (tile clock stopped = tile stalled).
- States: IDLE, TRST, TMODE, TCOEF, RUN, TMSB, TLSB, HOLD.
- start: honoured in IDLE, or in RUN with m_valid=0. Ignored elsewhere.
  - Latches cfg_lsb_mode and cfg_coef.
  - Goes to TRST with busy=1.
- TRST: 1 tick with bit1=1, data 0.
- TMODE: 1 tick with bit1=0 and data = {5'b0, lsb_mode}.
- TCOEF: N_TAPS ticks, data = coef[N_TAPS-1] first, down to coef[0] last. Then RUN, busy=0.
- RUN: s_ready=1 while in the LOW-idle point and (m_valid==0 or m_ready).
  - On handshake, TMSB: 1 tick with data = s_sample.
  - Captured byte → msb register.
- lsb_mode=1: then TLSB, 1 tick with data 0 (ignored by the tile); captured byte → lsb register.
- Result: m_result = {msb, lsb[4:0]} if lsb_mode, else {msb, 5'b0}.
  - m_valid rises on the cycle after the last capture.
  - Then RUN if the slot is free, else HOLD.
- HOLD: no ticks, s_ready=0; m_result/m_valid stable until m_ready; then RUN.
- Throughput at HALF_PERIOD=1 with m_ready=1: one sample / 2 cycles (MSB mode), / 4 cycles (LSB mode).
- Arithmetic: no saturation; the tile sum wraps modulo 2^13, and the host reports it bit-exact.
- Reset mid-operation: immediate return to reset values; any in-flight tick is abandoned. The tile needs a new start.

Test Plan:
- Reset → fir_io_in=8'h02, s_ready=0, m_valid=0, busy=0; no bit0 edges for 20 cycles.
- start, coef c3..c0 = 1,2,3,4, lsb_mode=0, HALF_PERIOD=1 → exactly 6 rising edges of bit0:
  - first with bit1=1;
  - then data 0, 1, 2, 3, 4;
  - busy falls, s_ready=1.
- Same coefs, lsb_mode=1, samples 31,0,0,0 → m_result = 124, 93, 62, 31.
- The same samples with lsb_mode=0 → m_result = 96, 64, 32, 0.
- All coefs −32, lsb_mode=1, four samples of −32 → fourth m_result = 13'h1000 (4096 wraps to −4096).
- m_ready=0 after the first result → bit0 static, s_ready=0, m_result stable 50 cycles.
  - Release → remaining results match the reference model, no loss or duplication.
- reset asserted during TCOEF → fir_io_in=8'h02 same cycle, state IDLE.
  - Fresh start with coefs 1,2,3,4 reproduces 124, 93, 62, 31.
